// File: rtl/fault_mem_cfg.sv
// Fault-injection memory with run-time configurable fault type, victim and aggressor.
// Two-stage pipeline: capture, commit (array write / read), then registered rdata.
module fault_mem_cfg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 16,
  localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  cfg_load,
  input  logic [2:0]            fault_type,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [BIT_W-1:0]      fault_bit,
  input  logic [ADDR_WIDTH-1:0] aggr_addr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  fault_hit
);

  typedef enum logic [2:0] {
    FtNone   = 3'd0,
    FtSaf0   = 3'd1,
    FtSaf1   = 3'd2,
    FtTfUp   = 3'd3,
    FtTfDown = 3'd4,
    FtCfidUp = 3'd5
  } fault_e;

  logic [DATA_WIDTH-1:0] mem_q [CAPACITY];

  logic                  s1_vld_q, s1_we_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_wdata_q;
  logic                  s2_rd_q, s2_hit_q;
  logic [DATA_WIDTH-1:0] s2_data_q, rdata_q;
  logic                  fault_hit_q;
  logic [2:0]            cfg_type_q;
  logic [ADDR_WIDTH-1:0] cfg_faddr_q, cfg_aggr_q;
  logic [BIT_W-1:0]      cfg_fbit_q;
  // Fault-free value of the victim bit, so reads can report a hit against the ideal memory.
  logic                  good_q, good_vld_q;

  logic                  in_range, vic_in_range, bit_ok, at_victim, cf_trig;
  logic                  old_b, new_b, wr_hit, rd_hit, mem_we, cf_set;
  logic [DATA_WIDTH-1:0] old_word, vic_word, wr_word, rd_word;

  always_comb begin
    in_range     = 32'(s1_addr_q) < CAPACITY;
    vic_in_range = 32'(cfg_faddr_q) < CAPACITY;
    bit_ok       = 32'(cfg_fbit_q) < DATA_WIDTH;
    old_word     = in_range ? mem_q[s1_addr_q] : '0;
    vic_word     = vic_in_range ? mem_q[cfg_faddr_q] : '0;
    at_victim    = in_range && bit_ok && (s1_addr_q == cfg_faddr_q);
    old_b        = old_word[cfg_fbit_q];
    new_b        = s1_wdata_q[cfg_fbit_q];

    wr_word = s1_wdata_q;
    if (at_victim) begin
      case (cfg_type_q)
        FtSaf0:   wr_word[cfg_fbit_q] = 1'b0;
        FtSaf1:   wr_word[cfg_fbit_q] = 1'b1;
        FtTfUp:   if (!old_b && new_b) wr_word[cfg_fbit_q] = 1'b0;
        FtTfDown: if (old_b && !new_b) wr_word[cfg_fbit_q] = 1'b1;
        default:  ;
      endcase
    end

    // Coupling is only armed when aggressor and victim are distinct, implemented words.
    cf_trig = (cfg_type_q == FtCfidUp) && bit_ok && vic_in_range && in_range &&
              (cfg_aggr_q != cfg_faddr_q) && (s1_addr_q == cfg_aggr_q) && !old_b && new_b;
    wr_hit  = (wr_word != s1_wdata_q) || (cf_trig && !vic_word[cfg_fbit_q]);

    rd_word = old_word;
    if (at_victim && (cfg_type_q == FtSaf0)) rd_word[cfg_fbit_q] = 1'b0;
    if (at_victim && (cfg_type_q == FtSaf1)) rd_word[cfg_fbit_q] = 1'b1;
    rd_hit = at_victim && (rd_word[cfg_fbit_q] != (good_vld_q ? good_q : old_b));

    mem_we = s1_vld_q && s1_we_q && in_range;
    cf_set = s1_vld_q && s1_we_q && cf_trig;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[s1_addr_q] <= wr_word;
    if (cf_set) mem_q[cfg_faddr_q][cfg_fbit_q] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_addr_q   <= '0;
      s1_wdata_q  <= '0;
      s2_rd_q     <= 1'b0;
      s2_hit_q    <= 1'b0;
      s2_data_q   <= '0;
      rdata_q     <= '0;
      fault_hit_q <= 1'b0;
      cfg_type_q  <= FtNone;
      cfg_faddr_q <= '0;
      cfg_aggr_q  <= '0;
      cfg_fbit_q  <= '0;
      good_q      <= 1'b0;
      good_vld_q  <= 1'b0;
    end else begin
      s1_vld_q   <= 1'b1;
      s1_we_q    <= write_read;
      s1_addr_q  <= address;
      s1_wdata_q <= wdata;
      s2_rd_q    <= s1_vld_q && !s1_we_q;
      if (s1_vld_q && !s1_we_q) s2_data_q <= rd_word;
      s2_hit_q   <= s1_vld_q && (s1_we_q ? wr_hit : rd_hit);
      if (s2_rd_q) rdata_q <= s2_data_q;
      fault_hit_q <= s2_hit_q;
      if (mem_we && at_victim) begin
        good_q     <= new_b;
        good_vld_q <= 1'b1;
      end
      if (cfg_load) begin
        cfg_type_q  <= fault_type;
        cfg_faddr_q <= fault_addr;
        cfg_aggr_q  <= aggr_addr;
        cfg_fbit_q  <= fault_bit;
        good_vld_q  <= 1'b0;
      end
    end
  end

  assign rdata     = rdata_q;
  assign fault_hit = fault_hit_q;

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Bench for fault_mem_cfg: directed fault scenarios plus randomized traffic checked
// against an ideal-memory/faulty-memory reference model.
module tb_fault_mem_cfg;
  localparam int CAP = 12;

  logic       clk = 1'b0, rst_n = 1'b0, write_read = 1'b0, cfg_load = 1'b0;
  logic [3:0] address = '0, fault_addr = '0, aggr_addr = '0;
  logic [7:0] wdata = '0;
  logic [2:0] fault_type = '0, fault_bit = '0;
  logic [7:0] rdata;
  logic       fault_hit;

  int n_pass = 0, n_total = 0;

  typedef struct {logic [7:0] rd; bit hit;} exp_t;
  exp_t pipe[$];

  int         m_mem[16], m_good[16];
  int         m_type, m_faddr, m_fbit, m_aggr;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  fault_mem_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .write_read(write_read), .address(address), .wdata(wdata),
    .cfg_load(cfg_load), .fault_type(fault_type), .fault_addr(fault_addr),
    .fault_bit(fault_bit), .aggr_addr(aggr_addr), .rdata(rdata), .fault_hit(fault_hit)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  // m_mem is what a faulty array holds, m_good what an ideal array would hold.
  task automatic model_commit(input bit we, input int a, input int d, output bit hit);
    int mask, old, st, v;
    mask = 1 << m_fbit;
    hit  = 1'b0;
    if (a >= CAP) begin
      if (!we) m_rdata = 8'h00;
      return;
    end
    if (we) begin
      old = m_mem[a];
      st  = d;
      if (a == m_faddr) begin
        case (m_type)
          1: st = st & ~mask;
          2: st = st | mask;
          3: if ((old & mask) == 0 && (d & mask) != 0) st = st & ~mask;
          4: if ((old & mask) != 0 && (d & mask) == 0) st = st | mask;
          default: ;
        endcase
      end
      hit       = (st != d);
      m_mem[a]  = st & 255;
      m_good[a] = d;
      if (m_type == 5 && a == m_aggr && m_aggr != m_faddr && m_faddr < CAP &&
          (old & mask) == 0 && (d & mask) != 0) begin
        if ((m_mem[m_faddr] & mask) == 0) hit = 1'b1;
        m_mem[m_faddr] = m_mem[m_faddr] | mask;
      end
    end else begin
      v = m_mem[a];
      if (a == m_faddr && m_type == 1) v = v & ~mask;
      if (a == m_faddr && m_type == 2) v = v | mask;
      hit     = (v != m_good[a]);
      m_rdata = v[7:0];
    end
  endtask

  // One request per clock; outputs are scored against the request issued two edges earlier.
  task automatic cyc(input bit we, input int a, input int d, input bit ld,
                     input int ty, input int fa, input int fb, input int ag);
    exp_t e;
    bit   h;
    write_read = we;
    address    = a[3:0];
    wdata      = d[7:0];
    cfg_load   = ld;
    fault_type = ty[2:0];
    fault_addr = fa[3:0];
    fault_bit  = fb[2:0];
    aggr_addr  = ag[3:0];
    @(posedge clk);
    if (ld) begin
      m_type = ty; m_faddr = fa; m_fbit = fb; m_aggr = ag;
    end
    model_commit(we, a, d, h);
    e.rd  = m_rdata;
    e.hit = h;
    pipe.push_back(e);
    #1;
    cfg_load = 1'b0;
    if (pipe.size() >= 3) begin
      e = pipe.pop_front();
      n_total++;
      if (rdata !== e.rd) $display("FAIL pipe_rdata: got %h want %h t=%0t", rdata, e.rd, $time);
      else n_pass++;
      n_total++;
      if (fault_hit !== e.hit)
        $display("FAIL pipe_hit: got %b want %b t=%0t", fault_hit, e.hit, $time);
      else n_pass++;
    end
  endtask

  task automatic wr(input int a, input int d); cyc(1'b1, a, d, 1'b0, 0, 0, 0, 0); endtask
  task automatic rd(input int a);              cyc(1'b0, a, 0, 1'b0, 0, 0, 0, 0); endtask
  task automatic idle();                       rd(15); endtask
  task automatic cfg(input int ty, input int fa, input int fb, input int ag);
    cyc(1'b0, 15, 0, 1'b1, ty, fa, fb, ag);
  endtask

  task automatic release_reset();
    exp_t e;
    @(negedge clk);
    rst_n  = 1'b1;
    m_type = 0; m_faddr = 0; m_fbit = 0; m_aggr = 0;
    m_rdata = 8'h00;
    e.rd = 8'h00; e.hit = 1'b0;
    pipe.delete();
    pipe.push_back(e);
    pipe.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata); else n_pass++;
    n_total++;
    if (fault_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", fault_hit); else n_pass++;
    release_reset();
  endtask

  task automatic test_fault_free();
    cfg(0, 0, 0, 0);
    wr(3, 8'hA5);
    rd(3);
    idle();
    n_total++;
    if (rdata === 8'hA5) $display("FAIL ff_early: got %h before latency elapsed", rdata);
    else n_pass++;
    idle();
    n_total++;
    if (rdata !== 8'hA5) $display("FAIL ff_rdata: got %h want a5", rdata); else n_pass++;
  endtask

  task automatic test_saf1();
    cfg(2, 5, 0, 0);
    wr(5, 8'h00);
    rd(5);
    idle();
    n_total++;
    if (fault_hit !== 1'b1) $display("FAIL saf1_wr_hit: got %b want 1", fault_hit); else n_pass++;
    idle();
    n_total++;
    if (rdata !== 8'h01) $display("FAIL saf1_rdata: got %h want 01", rdata); else n_pass++;
    n_total++;
    if (fault_hit !== 1'b1) $display("FAIL saf1_rd_hit: got %b want 1", fault_hit); else n_pass++;
  endtask

  task automatic test_tf_down();
    cfg(4, 5, 0, 0);
    wr(5, 8'hFF);
    wr(5, 8'hFE);
    rd(5);
    idle();
    idle();
    n_total++;
    if (rdata !== 8'hFF) $display("FAIL tfd_rdata: got %h want ff", rdata); else n_pass++;
    wr(6, 8'h00);
    rd(6);
    idle();
    idle();
    n_total++;
    if (rdata !== 8'h00) $display("FAIL tfd_other: got %h want 00", rdata); else n_pass++;
  endtask

  task automatic test_cfid_up();
    cfg(5, 5, 2, 9);
    wr(5, 8'h00);
    wr(9, 8'h00);
    wr(9, 8'h04);
    rd(5);
    wr(9, 8'h04);
    n_total++;
    if (fault_hit !== 1'b1) $display("FAIL cfid_trig_hit: got %b want 1", fault_hit); else n_pass++;
    idle();
    idle();
    n_total++;
    if (rdata !== 8'h04) $display("FAIL cfid_rdata: got %h want 04", rdata); else n_pass++;
    n_total++;
    if (fault_hit !== 1'b0) $display("FAIL cfid_repeat_hit: got %b want 0", fault_hit); else n_pass++;
  endtask

  task automatic test_boundary_back_to_back();
    cfg(0, 0, 0, 0);
    wr(11, 8'h3C);
    rd(11);
    wr(13, 8'h55);
    rd(13);
    n_total++;
    if (rdata !== 8'h3C) $display("FAIL b2b_rdata: got %h want 3c", rdata); else n_pass++;
    idle();
    idle();
    n_total++;
    if (rdata !== 8'h00) $display("FAIL oor_rdata: got %h want 00", rdata); else n_pass++;
  endtask

  task automatic test_cfg_same_edge();
    cyc(1'b1, 7, 8'h00, 1'b1, 2, 7, 6, 0);
    rd(7);
    idle();
    idle();
    n_total++;
    if (rdata !== 8'h40) $display("FAIL cfg_edge_rdata: got %h want 40", rdata); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    cfg(1, 5, 4, 0);
    wr(5, 8'hF0);
    rd(5);
    idle();
    rd(5);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", rdata); else n_pass++;
    n_total++;
    if (fault_hit !== 1'b0) $display("FAIL rst_hit: got %b want 0", fault_hit); else n_pass++;
    @(posedge clk);
    release_reset();
    wr(5, 8'hF0);
    rd(5);
    idle();
    idle();
    n_total++;
    if (rdata !== 8'hF0) $display("FAIL rst_cfg_none: got %h want f0", rdata); else n_pass++;
  endtask

  task automatic test_random();
    int types[7];
    int ty, fa, fb, ag, a;
    types = '{5, 4, 3, 2, 1, 0, 6};
    for (int s = 0; s < 7; s++) begin
      ty = types[s];
      fa = $urandom_range(0, 13);
      fb = $urandom_range(0, 7);
      ag = $urandom_range(0, 12);
      cfg(ty, fa, fb, ag);
      for (int w = 0; w < CAP; w++) wr(w, $urandom_range(0, 255));
      for (int k = 0; k < 80; k++) begin
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) a = ag;
        else if ($urandom_range(0, 3) == 0) a = fa;
        cyc($urandom_range(0, 1) == 1, a, $urandom_range(0, 255), 1'b0, 0, 0, 0, 0);
      end
    end
    idle();
    idle();
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_saf1();
    test_tf_down();
    test_cfid_up();
    test_boundary_back_to_back();
    test_cfg_same_edge();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fault_mem_cfg.md
Name:
fault_mem_cfg

Overview:
- Parametrised, runtime-configurable fault-injection memory model used as the device under test for the MBIST controller.
- Supersedes the fixed single-fault memories. Fault type, victim address, victim bit and aggressor address are registers loaded at run time, so one netlist covers stuck-at, transition and coupling faults.
- The MBIST engine drives write_read, address and wdata as it does for the existing fault memories, and compares rdata.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width.
- CAPACITY, 16, number of implemented words. Addresses >= CAPACITY are out of range.
- BIT_W, $clog2(DATA_WIDTH) (minimum 1), width of the bit-index field. This is a localparam.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- write_read  in  1  1 = write request, 0 = read request. Sampled every cycle.
- address  in  ADDR_WIDTH  request address.
- wdata  in  DATA_WIDTH  write data.
- cfg_load  in  1  when 1, loads fault_type, fault_addr, fault_bit and aggr_addr into the config registers.
- fault_type  in  3  0 none, 1 SAF0, 2 SAF1, 3 TF-up, 4 TF-down, 5 CFid-up, 6/7 treated as none.
- fault_addr  in  ADDR_WIDTH  victim word address.
- fault_bit  in  BIT_W  victim bit index; also the aggressor bit index.
- aggr_addr  in  ADDR_WIDTH  aggressor word address (CFid-up only).
- rdata  out  DATA_WIDTH  read data, registered.
- fault_hit  out  1  one-cycle pulse when the injected fault changed a stored or returned value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears the stage-1 registers (s1_we, s1_addr, s1_wdata), the stage-2 read register, rdata, fault_hit and the config registers (type = none, all addresses and indices = 0).
  - Array contents are not reset and are undefined until written.
  - Reset mid-operation discards any in-flight request.
- Pipeline:
  - Edge N: the request is captured into stage 1.
  - Edge N+1 (commit stage):
    - A write updates the array.
    - A read loads the array word into the stage-2 read register.
  - Edge N+2: rdata takes the stage-2 value, giving a read latency of 2 cycles.
  - rdata holds its value while no read is in flight.
- Ordering: a write at N followed by a read of the same address at N+1 returns the new data. Requests may be issued every cycle.
- Out of range (s1_addr >= CAPACITY): a write is ignored; a read returns all zeros and fault_hit = 0.
- Config:
  - Registers load on any edge with cfg_load = 1.
  - The commit stage always uses the current config register values. A write captured at edge N, with cfg_load at edge N, commits under the new config.
- Fault rules, applied only when s1_addr == cfg fault_addr and only to bit cfg fault_bit (other bits behave normally). "old" and "new" are the stored and incoming values of that bit.
  - SAF0: the stored bit is written as 0; a read returns the bit as 0.
  - SAF1: the stored bit is written as 1; a read returns the bit as 1.
  - TF-up: old = 0 and new = 1 → the bit stays 0.
  - TF-down: old = 1 and new = 0 → the bit stays 1.
  - CFid-up: the rule is triggered by a write to aggr_addr, not by a write to the victim.
    - On that write, if the aggressor bit goes 0→1, the victim word's fault_bit is set to 1 in the same commit cycle. The aggressor itself is stored normally.
    - If aggr_addr == fault_addr, or aggr_addr is out of range, the coupling fault is inactive.
    - A direct write to the victim word under CFid-up is fault-free.
- fault_hit:
  - Registered.
  - Set at edge N+2 for one cycle when the faulty stored value (write) or faulty returned value (read) differs from the fault-free value.
  - Otherwise 0.

Test Plan:
- Fault-free: type 0. Write 0xA5 to address 3, then read address 3 → rdata = 0xA5 exactly 2 cycles after the read request; fault_hit stays 0.
- SAF1 at fault_addr 5, bit 0: write 0x00 to address 5, then read → rdata = 0x01. fault_hit pulses after both the write and the read.
- TF-down at fault_addr 5, bit 0: write 0xFF, then 0xFE, then read → rdata = 0xFF. Then write 0x00 to address 6 and read → 0x00.
- CFid-up with victim 5 bit 2, aggressor 9: write 0x00 to address 5, 0x00 to address 9, then 0x04 to address 9; read address 5 → 0x04. A repeated write of 0x04 to address 9 causes no new fault_hit.
- Boundary, CAPACITY 12: write 0x55 to address 13, then read address 13 → rdata = 0x00. Back-to-back write/read of address 11 returns the written data.
- Reset: assert rst_n low while a read is in flight → rdata = 0, fault_hit = 0 and config = none. Writing and reading after release are fault-free.
